// File: rtl/hh_pkg.sv
// Shared types and helpers for the Hodgkin-Huxley gating controller.
// Gate values are signed 16-bit fixed point scaled by FX_SCALE.
package hh_pkg;

    localparam logic [1:0] GATE_M = 2'd0;
    localparam logic [1:0] GATE_H = 2'd1;
    localparam logic [1:0] GATE_N = 2'd2;

    localparam int FX_SCALE = 1000;

    typedef logic signed [15:0] fx16_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } hh_state_e;

    // Limit a gate value to the physical range [0, hi].
    function automatic fx16_t fx_clamp(input fx16_t val, input fx16_t hi);
        fx16_t res;
        if (val < 16'sd0) begin
            res = 16'sd0;
        end else if (val > hi) begin
            res = hi;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/hh_gate_watchdog.sv
// Response timer for the gate unit: counts cycles spent waiting and flags
// expiry on the TIMEOUT-th waiting cycle.
module hh_gate_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_expired = w_expired;

    // Holds at the expiry value so the flag stays asserted until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hh_gate_sequencer.sv
// Per-timestep controller: issues m, h, n updates to a shared gate unit,
// commits clamped results and counts error-free steps.
module hh_gate_sequencer
    import hh_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int STEP_W  = 16,
    parameter int M_INIT  = 53,
    parameter int H_INIT  = 600,
    parameter int N_INIT  = 318,
    parameter int X_MAX   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic signed [15:0] v_mem,
    input  logic signed [15:0] dt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              gate_req_valid,
    input  logic              gate_req_ready,
    output logic [1:0]        gate_sel,
    output logic signed [15:0] gate_v,
    output logic signed [15:0] gate_x,
    output logic signed [15:0] gate_dt,
    input  logic              gate_rsp_valid,
    input  logic signed [15:0] gate_rsp_x,
    output logic signed [15:0] m_q,
    output logic signed [15:0] h_q,
    output logic signed [15:0] n_q,
    output logic [STEP_W-1:0] step_cnt
);

    localparam fx16_t W_XMAX = fx16_t'(X_MAX);
    localparam fx16_t W_MINI = fx16_t'(M_INIT);
    localparam fx16_t W_HINI = fx16_t'(H_INIT);
    localparam fx16_t W_NINI = fx16_t'(N_INIT);

    hh_state_e        r_state;
    hh_state_e        w_state_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    fx16_t            r_v;
    fx16_t            r_dt;
    fx16_t            r_m;
    fx16_t            r_h;
    fx16_t            r_n;
    logic             r_err;
    logic [STEP_W-1:0] r_step;

    logic             w_accept;
    logic             w_commit;
    logic             w_timeout;
    logic             w_expired;
    logic             w_in_wait;
    fx16_t            w_rsp_clamped;
    fx16_t            w_gate_x;

    assign w_in_wait     = (r_state == ST_WAIT);
    assign w_rsp_clamped = fx_clamp(gate_rsp_x, W_XMAX);

    hh_gate_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    // A response in the expiry cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_sel_nxt   = GATE_M;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gate_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (gate_rsp_valid) begin
                    w_commit = 1'b1;
                    if (r_sel == GATE_N) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_sel_nxt   = r_sel + 2'd1;
                        w_state_nxt = ST_ISSUE;
                    end
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= GATE_M;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_dt  <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_v   <= v_mem;
            r_dt  <= dt;
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= W_MINI;
            r_h <= W_HINI;
            r_n <= W_NINI;
        end else if (w_commit) begin
            case (r_sel)
                GATE_M:  r_m <= w_rsp_clamped;
                GATE_H:  r_h <= w_rsp_clamped;
                GATE_N:  r_n <= w_rsp_clamped;
                default: r_m <= r_m;
            endcase
        end
    end

    // An aborted step is still reported by done but is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
        end else if ((r_state == ST_DONE) && !r_err) begin
            r_step <= r_step + STEP_W'(1);
        end
    end

    always_comb begin
        w_gate_x = r_m;
        case (r_sel)
            GATE_H:  w_gate_x = r_h;
            GATE_N:  w_gate_x = r_n;
            default: w_gate_x = r_m;
        endcase
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign err            = r_err;
    assign gate_req_valid = (r_state == ST_ISSUE);
    assign gate_sel       = r_sel;
    assign gate_v         = r_v;
    assign gate_x         = w_gate_x;
    assign gate_dt        = r_dt;
    assign m_q            = r_m;
    assign h_q            = r_h;
    assign n_q            = r_n;
    assign step_cnt       = r_step;

endmodule
